// File: rtl/dpbram_be.sv
// True dual-port RAM with per-byte write enables, selectable read-during-write
// behaviour, optional output register stage and a post-reset zero-fill sequencer.
module dpbram_be #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned RD_MODE    = 0,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             init_busy,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [ADDR_WIDTH-1:0]            addr1,
  input  logic                             ce0,
  input  logic                             ce1,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we0,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we1,
  input  logic [DATA_WIDTH-1:0]            d0,
  input  logic [DATA_WIDTH-1:0]            d1,
  output logic [DATA_WIDTH-1:0]            q0,
  output logic [DATA_WIDTH-1:0]            q1,
  output logic                             qv0,
  output logic                             qv1,
  output logic                             collision,
  input  logic                             collision_clr
);

  localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] ADDR_LIM = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [IW-1:0]       LAST_IDX = IW'(MEM_SIZE - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  state_e          state_q;
  logic [IW-1:0]   cnt_q;
  logic            init_busy_q;
  logic            collision_q;

  logic [ADDR_WIDTH-1:0] addr_w [2];
  logic [NB-1:0]         we_w   [2];
  logic                  ce_w   [2];
  logic                  act_w  [2];
  logic                  inr_w  [2];
  logic                  wr_w   [2];
  logic [IW-1:0]         idx_w  [2];
  logic [DATA_WIDTH-1:0] old_w  [2];
  logic [DATA_WIDTH-1:0] new_w  [2];
  logic                  conflict_w;
  logic                  clr_we_w;

  logic [DATA_WIDTH-1:0] rdq_d [2];
  logic [DATA_WIDTH-1:0] rdq_q [2];
  logic                  rdv_d [2];
  logic                  rdv_q [2];

  // Port decode: user access is masked for the whole clear sequence.
  always_comb begin
    addr_w[0] = addr0;
    addr_w[1] = addr1;
    we_w[0]   = we0;
    we_w[1]   = we1;
    ce_w[0]   = ce0;
    ce_w[1]   = ce1;
    for (int p = 0; p < 2; p++) begin
      act_w[p] = ce_w[p] & ~init_busy_q;
      inr_w[p] = {1'b0, addr_w[p]} < ADDR_LIM;
      idx_w[p] = IW'(addr_w[p]);
      wr_w[p]  = act_w[p] & inr_w[p] & (|we_w[p]);
      old_w[p] = inr_w[p] ? mem[idx_w[p]] : '0;
    end
  end

  // Cross-port conflict and the post-write word seen at each port's address.
  always_comb begin
    conflict_w = act_w[0] & act_w[1] & inr_w[0] & inr_w[1] &
                 (addr0 == addr1) & ((|we0) | (|we1));
    new_w[0]   = old_w[0];
    new_w[1]   = old_w[1];
    for (int i = 0; i < NB; i++) begin
      if (we0[i]) begin
        new_w[0][i*BYTE_WIDTH +: BYTE_WIDTH] = d0[i*BYTE_WIDTH +: BYTE_WIDTH];
      end else if (conflict_w && we1[i]) begin
        new_w[0][i*BYTE_WIDTH +: BYTE_WIDTH] = d1[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (conflict_w && we0[i]) begin
        new_w[1][i*BYTE_WIDTH +: BYTE_WIDTH] = d0[i*BYTE_WIDTH +: BYTE_WIDTH];
      end else if (we1[i]) begin
        new_w[1][i*BYTE_WIDTH +: BYTE_WIDTH] = d1[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign clr_we_w = (state_q == CLEAR) & ~rst;

  // Storage: port 1 lanes are written first so port 0 overrides on shared lanes.
  always_ff @(posedge clk) begin
    if (clr_we_w) begin
      mem[cnt_q] <= '0;
    end
    for (int i = 0; i < NB; i++) begin
      if (wr_w[1] && we1[i]) begin
        mem[idx_w[1]][i*BYTE_WIDTH +: BYTE_WIDTH] <= d1[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (wr_w[0] && we0[i]) begin
        mem[idx_w[0]][i*BYTE_WIDTH +: BYTE_WIDTH] <= d0[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Clear sequencer: one zero word per cycle, then hand the ports to the user.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (INIT_CLEAR != 0) ? CLEAR : READY;
      cnt_q       <= '0;
      init_busy_q <= (INIT_CLEAR != 0);
    end else begin
      case (state_q)
        CLEAR: begin
          if (cnt_q == LAST_IDX) begin
            state_q     <= READY;
            cnt_q       <= '0;
            init_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + IW'(1);
          end
        end
        default: begin
          state_q     <= READY;
          init_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // First read stage: read-first, write-first or no-change on a same-port write.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdq_d[p] = rdq_q[p];
      rdv_d[p] = 1'b0;
      if (act_w[p]) begin
        if ((we_w[p] == '0) || (RD_MODE == 0)) begin
          rdq_d[p] = old_w[p];
          rdv_d[p] = 1'b1;
        end else if (RD_MODE == 1) begin
          rdq_d[p] = inr_w[p] ? new_w[p] : '0;
          rdv_d[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        rdq_q[p] <= '0;
        rdv_q[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        rdq_q[p] <= rdq_d[p];
        rdv_q[p] <= rdv_d[p];
      end
    end
  end

  // Sticky conflict flag; a new conflict outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      collision_q <= 1'b0;
    end else if (conflict_w) begin
      collision_q <= 1'b1;
    end else if (collision_clr) begin
      collision_q <= 1'b0;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] oq_q [2];
    logic                  ov_q [2];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int p = 0; p < 2; p++) begin
          oq_q[p] <= '0;
          ov_q[p] <= 1'b0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          oq_q[p] <= rdq_q[p];
          ov_q[p] <= rdv_q[p];
        end
      end
    end

    assign q0  = oq_q[0];
    assign q1  = oq_q[1];
    assign qv0 = ov_q[0];
    assign qv1 = ov_q[1];
  end else begin : g_noreg
    assign q0  = rdq_q[0];
    assign q1  = rdq_q[1];
    assign qv0 = rdv_q[0];
    assign qv1 = rdv_q[1];
  end

  assign init_busy = init_busy_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_dpbram_be.sv
// Bench for dpbram_be: three configurations driven in parallel (read-first,
// write-first with output register, no-change with a short memory).
module tb_dpbram_be;

  localparam int MS   [3] = '{1024, 1024, 1000};
  localparam int RDM  [3] = '{0, 1, 2};
  localparam int OREG [3] = '{0, 1, 0};

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addr0, addr1;
  logic        ce0, ce1;
  logic [3:0]  we0, we1;
  logic [31:0] d0, d1;
  logic        collision_clr;

  logic        init_busy_w [3];
  logic [31:0] q0_w [3];
  logic [31:0] q1_w [3];
  logic        qv0_w [3];
  logic        qv1_w [3];
  logic        coll_w [3];

  int checks   = 0;
  int failures = 0;

  // Reference state: memory image, clear progress and per-port read results.
  logic [31:0] mm [3][1024];
  bit          busy_m [3];
  int          left_m [3];
  bit          coll_m [3];
  logic [31:0] rn_q [3][2];
  logic [31:0] rp_q [3][2];
  bit          rn_v [3][2];
  bit          rp_v [3][2];

  always #5 clk = ~clk;

  dpbram_be #(.RD_MODE(0), .OUT_REG(0), .MEM_SIZE(1024)) u_a (
    .clk(clk), .rst(rst), .init_busy(init_busy_w[0]),
    .addr0(addr0), .addr1(addr1), .ce0(ce0), .ce1(ce1), .we0(we0), .we1(we1),
    .d0(d0), .d1(d1), .q0(q0_w[0]), .q1(q1_w[0]), .qv0(qv0_w[0]), .qv1(qv1_w[0]),
    .collision(coll_w[0]), .collision_clr(collision_clr));

  dpbram_be #(.RD_MODE(1), .OUT_REG(1), .MEM_SIZE(1024)) u_b (
    .clk(clk), .rst(rst), .init_busy(init_busy_w[1]),
    .addr0(addr0), .addr1(addr1), .ce0(ce0), .ce1(ce1), .we0(we0), .we1(we1),
    .d0(d0), .d1(d1), .q0(q0_w[1]), .q1(q1_w[1]), .qv0(qv0_w[1]), .qv1(qv1_w[1]),
    .collision(coll_w[1]), .collision_clr(collision_clr));

  dpbram_be #(.RD_MODE(2), .OUT_REG(0), .MEM_SIZE(1000)) u_c (
    .clk(clk), .rst(rst), .init_busy(init_busy_w[2]),
    .addr0(addr0), .addr1(addr1), .ce0(ce0), .ce1(ce1), .we0(we0), .we1(we1),
    .d0(d0), .d1(d1), .q0(q0_w[2]), .q1(q1_w[2]), .qv0(qv0_w[2]), .qv1(qv1_w[2]),
    .collision(coll_w[2]), .collision_clr(collision_clr));

  function automatic logic [31:0] eq(int k, int p);
    return (OREG[k] != 0) ? rp_q[k][p] : rn_q[k][p];
  endfunction

  function automatic bit ev(int k, int p);
    return (OREG[k] != 0) ? rp_v[k][p] : rn_v[k][p];
  endfunction

  // Apply one clock edge of the specified behaviour to every configuration.
  task automatic model_edge();
    logic [9:0]  a [2];
    logic [3:0]  w [2];
    logic [31:0] d [2];
    bit          c [2];
    a[0] = addr0; a[1] = addr1; w[0] = we0; w[1] = we1;
    d[0] = d0;    d[1] = d1;    c[0] = ce0; c[1] = ce1;
    for (int k = 0; k < 3; k++) begin
      bit          act [2];
      bit          inr [2];
      logic [31:0] old [2];
      logic [31:0] fin [2];
      bit          conf;
      if (rst) begin
        busy_m[k] = 1'b1;
        left_m[k] = MS[k];
        coll_m[k] = 1'b0;
        for (int p = 0; p < 2; p++) begin
          rn_q[k][p] = '0; rp_q[k][p] = '0; rn_v[k][p] = 1'b0; rp_v[k][p] = 1'b0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          act[p] = c[p] && !busy_m[k];
          inr[p] = int'(a[p]) < MS[k];
          old[p] = inr[p] ? mm[k][a[p]] : 32'h0;
        end
        conf = act[0] && act[1] && inr[0] && inr[1] && (a[0] == a[1]) && ((w[0] | w[1]) != 4'h0);
        for (int p = 1; p >= 0; p--) begin
          if (act[p] && inr[p]) begin
            for (int l = 0; l < 4; l++) begin
              if (w[p][l]) mm[k][a[p]][8*l +: 8] = d[p][8*l +: 8];
            end
          end
        end
        for (int p = 0; p < 2; p++) begin
          fin[p] = inr[p] ? mm[k][a[p]] : 32'h0;
          rp_q[k][p] = rn_q[k][p];
          rp_v[k][p] = rn_v[k][p];
          if (!act[p]) begin
            rn_v[k][p] = 1'b0;
          end else if (w[p] == 4'h0 || RDM[k] == 0) begin
            rn_q[k][p] = old[p]; rn_v[k][p] = 1'b1;
          end else if (RDM[k] == 1) begin
            rn_q[k][p] = fin[p]; rn_v[k][p] = 1'b1;
          end else begin
            rn_v[k][p] = 1'b0;
          end
        end
        if (conf) coll_m[k] = 1'b1;
        else if (collision_clr) coll_m[k] = 1'b0;
        if (busy_m[k]) begin
          left_m[k]--;
          if (left_m[k] == 0) begin
            busy_m[k] = 1'b0;
            for (int i = 0; i < 1024; i++) mm[k][i] = '0;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    ce0 = 1'b0; ce1 = 1'b0; we0 = 4'h0; we1 = 4'h0; collision_clr = 1'b0;
  endtask

  task automatic rand_in();
    addr0 = ($urandom % 6 == 0) ? 10'(1000 + $urandom % 24) : 10'($urandom % 8);
    addr1 = ($urandom % 6 == 0) ? 10'(1000 + $urandom % 24) : 10'($urandom % 8);
    ce0 = 1'($urandom % 4 != 0);
    ce1 = 1'($urandom % 4 != 0);
    we0 = ($urandom % 2 == 1) ? 4'($urandom) : 4'h0;
    we1 = ($urandom % 2 == 1) ? 4'($urandom) : 4'h0;
    d0 = $urandom;
    d1 = $urandom;
    collision_clr = 1'($urandom % 8 == 0);
  endtask

  task automatic test_reset();
    int done_at [3];
    bit bad [3];
    int n;
    rst = 1'b1; addr0 = '0; addr1 = '0; d0 = '0; d1 = '0;
    idle_in();
    repeat (3) cycle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({init_busy_w[k], qv0_w[k], qv1_w[k], coll_w[k], q0_w[k], q1_w[k]} !== {1'b1, 3'b000, 64'h0}) begin
        failures++;
        $display("FAIL reset_state dut%0d got busy=%b qv=%b%b coll=%b q0=%h q1=%h want 1 00 0 0 0",
                 k, init_busy_w[k], qv0_w[k], qv1_w[k], coll_w[k], q0_w[k], q1_w[k]);
      end
      done_at[k] = -1; bad[k] = 1'b0;
    end
    rst = 1'b0; n = 0;
    while ((done_at[0] < 0 || done_at[1] < 0 || done_at[2] < 0) && n < 2000) begin
      if (n < 990) rand_in(); else idle_in();
      cycle(); n++;
      for (int k = 0; k < 3; k++) begin
        if (init_busy_w[k] === 1'b0 && done_at[k] < 0) done_at[k] = n;
        if (n <= MS[k] && (qv0_w[k] !== 1'b0 || qv1_w[k] !== 1'b0)) bad[k] = 1'b1;
      end
    end
    idle_in();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (done_at[k] != MS[k]) begin
        failures++;
        $display("FAIL clear_len dut%0d got %0d want %0d", k, done_at[k], MS[k]);
      end
      checks++;
      if (bad[k]) begin
        failures++;
        $display("FAIL clear_mask dut%0d got qv=1 during clear want qv=0", k);
      end
    end
    ce0 = 1'b1; addr0 = 10'd0; ce1 = 1'b1; addr1 = 10'd511;
    cycle();
    for (int k = 0; k < 3; k += 2) begin
      checks++;
      if ({q0_w[k], qv0_w[k], q1_w[k], qv1_w[k]} !== {32'h0, 1'b1, 32'h0, 1'b1}) begin
        failures++;
        $display("FAIL clear_rd_0_511 dut%0d got %h/%b %h/%b want 0/1 0/1", k, q0_w[k], qv0_w[k], q1_w[k], qv1_w[k]);
      end
    end
    addr0 = 10'd1023; ce1 = 1'b0;
    cycle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (q0_w[k] !== 32'h0 || qv0_w[k] !== 1'b1) begin
        failures++;
        $display("FAIL clear_rd_1023 dut%0d got %h/%b want 0/1", k, q0_w[k], qv0_w[k]);
      end
    end
    idle_in();
    cycle();
    checks++;
    if (q0_w[1] !== 32'h0 || qv0_w[1] !== 1'b1 || qv1_w[1] !== 1'b0) begin
      failures++;
      $display("FAIL clear_rd_oreg got %h/%b qv1=%b want 0/1 qv1=0", q0_w[1], qv0_w[1], qv1_w[1]);
    end
    cycle();
  endtask

  task automatic test_byte_enable();
    ce0 = 1'b1; addr0 = 10'd5; we0 = 4'hF; d0 = 32'hAABBCCDD;
    cycle();
    we0 = 4'h5; d0 = 32'h11223344;
    cycle();
    checks++;
    if (q0_w[0] !== 32'hAABBCCDD || qv0_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL be_read_first got %h/%b want aabbccdd/1", q0_w[0], qv0_w[0]);
    end
    we0 = 4'h0; ce1 = 1'b1; addr1 = 10'd5;
    cycle();
    for (int k = 0; k < 3; k += 2) begin
      checks++;
      if (q0_w[k] !== 32'hAA22CC44 || qv0_w[k] !== 1'b1 || q1_w[k] !== 32'hAA22CC44) begin
        failures++;
        $display("FAIL be_merge dut%0d got %h/%b %h want aa22cc44/1 aa22cc44", k, q0_w[k], qv0_w[k], q1_w[k]);
      end
    end
    checks++;
    if (coll_w[0] !== 1'b0 || coll_w[1] !== 1'b0) begin
      failures++;
      $display("FAIL rr_no_coll got %b%b want 00", coll_w[0], coll_w[1]);
    end
    idle_in();
    cycle();
    checks++;
    if (q0_w[1] !== 32'hAA22CC44 || qv0_w[1] !== 1'b1) begin
      failures++;
      $display("FAIL be_merge_oreg got %h/%b want aa22cc44/1", q0_w[1], qv0_w[1]);
    end
  endtask

  task automatic test_rd_mode();
    ce0 = 1'b1; addr0 = 10'd5; we0 = 4'h0;
    cycle();
    addr0 = 10'd9; we0 = 4'hF; d0 = 32'hDEADBEEF;
    cycle();
    d0 = 32'h12345678;
    cycle();
    checks++;
    if (q0_w[0] !== 32'hDEADBEEF || qv0_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL rdm0 got %h/%b want deadbeef/1", q0_w[0], qv0_w[0]);
    end
    checks++;
    if (q0_w[2] !== 32'hAA22CC44 || qv0_w[2] !== 1'b0) begin
      failures++;
      $display("FAIL rdm2 got %h/%b want aa22cc44/0", q0_w[2], qv0_w[2]);
    end
    checks++;
    if (q0_w[1] !== 32'hDEADBEEF || qv0_w[1] !== 1'b1) begin
      failures++;
      $display("FAIL rdm1_first got %h/%b want deadbeef/1", q0_w[1], qv0_w[1]);
    end
    idle_in();
    cycle();
    checks++;
    if (q0_w[1] !== 32'h12345678 || qv0_w[1] !== 1'b1) begin
      failures++;
      $display("FAIL rdm1 got %h/%b want 12345678/1", q0_w[1], qv0_w[1]);
    end
  endtask

  task automatic test_collision_ww();
    ce0 = 1'b1; ce1 = 1'b1; addr0 = 10'd3; addr1 = 10'd3;
    we0 = 4'b0011; d0 = 32'h000000AA; we1 = 4'b1110; d1 = 32'hBB000000;
    cycle();
    checks++;
    if ({coll_w[0], coll_w[1], coll_w[2]} !== 3'b111) begin
      failures++;
      $display("FAIL ww_coll_set got %b%b%b want 111", coll_w[0], coll_w[1], coll_w[2]);
    end
    idle_in();
    cycle();
    ce0 = 1'b1; addr0 = 10'd3;
    cycle();
    checks++;
    if (q0_w[0] !== 32'hBB0000AA || q0_w[2] !== 32'hBB0000AA || coll_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL ww_merge got %h %h coll=%b want bb0000aa bb0000aa 1", q0_w[0], q0_w[2], coll_w[0]);
    end
    idle_in(); collision_clr = 1'b1;
    cycle();
    checks++;
    if ({coll_w[0], coll_w[1], coll_w[2]} !== 3'b000 || q0_w[1] !== 32'hBB0000AA) begin
      failures++;
      $display("FAIL ww_clr got coll=%b%b%b q0b=%h want 000 bb0000aa", coll_w[0], coll_w[1], coll_w[2], q0_w[1]);
    end
    ce0 = 1'b1; addr0 = 10'd3; ce1 = 1'b1; addr1 = 10'd3; we1 = 4'b0001; d1 = 32'h000000CC;
    cycle();
    checks++;
    if (coll_w[0] !== 1'b1 || q0_w[0] !== 32'hBB0000AA) begin
      failures++;
      $display("FAIL set_wins got coll=%b q0=%h want 1 bb0000aa", coll_w[0], q0_w[0]);
    end
    idle_in(); collision_clr = 1'b1;
    cycle();
    collision_clr = 1'b0;
  endtask

  task automatic test_rw_conflict();
    ce0 = 1'b1; addr0 = 10'd7; we0 = 4'hF; d0 = 32'h1;
    cycle();
    d0 = 32'h2; ce1 = 1'b1; addr1 = 10'd7;
    cycle();
    checks++;
    if (q1_w[0] !== 32'h1 || qv1_w[0] !== 1'b1 || q1_w[2] !== 32'h1 || coll_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL rw_old got %h/%b %h coll=%b want 1/1 1 1", q1_w[0], qv1_w[0], q1_w[2], coll_w[0]);
    end
    ce0 = 1'b0; we0 = 4'h0;
    cycle();
    checks++;
    if (q1_w[0] !== 32'h2 || q1_w[1] !== 32'h1 || q0_w[1] !== 32'h2) begin
      failures++;
      $display("FAIL rw_next got %h b:%h/%h want 2 b:1/2", q1_w[0], q1_w[1], q0_w[1]);
    end
    idle_in();
    cycle();
    checks++;
    if (q1_w[1] !== 32'h2 || qv1_w[1] !== 1'b1 || coll_w[1] !== 1'b1) begin
      failures++;
      $display("FAIL rw_next_oreg got %h/%b coll=%b want 2/1 1", q1_w[1], qv1_w[1], coll_w[1]);
    end
    collision_clr = 1'b1;
    cycle();
    collision_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 4; j++) begin
      ce1 = 1'b1; addr1 = 10'(20 + j); we1 = 4'hF; d1 = 32'hC0DE0000 + 32'(j);
      cycle();
    end
    idle_in();
    for (int j = 0; j < 4; j++) begin
      ce0 = 1'b1; addr0 = 10'(20 + j);
      cycle();
      checks++;
      if (q0_w[0] !== 32'hC0DE0000 + 32'(j) || qv0_w[0] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_a%0d got %h/%b want %h/1", j, q0_w[0], qv0_w[0], 32'hC0DE0000 + 32'(j));
      end
      if (j > 0) begin
        checks++;
        if (q0_w[1] !== 32'hC0DE0000 + 32'(j - 1) || qv0_w[1] !== 1'b1) begin
          failures++;
          $display("FAIL b2b_b%0d got %h/%b want %h/1", j - 1, q0_w[1], qv0_w[1], 32'hC0DE0000 + 32'(j - 1));
        end
      end
    end
    idle_in();
    cycle();
    checks++;
    if (q0_w[1] !== 32'hC0DE0003 || qv0_w[1] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_b3 got %h/%b want c0de0003/1", q0_w[1], qv0_w[1]);
    end
    cycle();
    checks++;
    if (qv0_w[1] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got qv=%b want 0", qv0_w[1]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rand_in();
      cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (init_busy_w[k] !== busy_m[k] || coll_w[k] !== coll_m[k]) begin
          failures++;
          $display("FAIL rnd_flags dut%0d cyc%0d got busy=%b coll=%b want %b %b",
                   k, n, init_busy_w[k], coll_w[k], busy_m[k], coll_m[k]);
        end
        checks++;
        if (q0_w[k] !== eq(k, 0) || qv0_w[k] !== ev(k, 0)) begin
          failures++;
          $display("FAIL rnd_p0 dut%0d cyc%0d got %h/%b want %h/%b", k, n, q0_w[k], qv0_w[k], eq(k, 0), ev(k, 0));
        end
        checks++;
        if (q1_w[k] !== eq(k, 1) || qv1_w[k] !== ev(k, 1)) begin
          failures++;
          $display("FAIL rnd_p1 dut%0d cyc%0d got %h/%b want %h/%b", k, n, q1_w[k], qv1_w[k], eq(k, 1), ev(k, 1));
        end
      end
    end
    idle_in();
    cycle();
  endtask

  task automatic test_midclear();
    int done_at [3];
    int n;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (300) cycle();
    checks++;
    if ({init_busy_w[0], init_busy_w[1], init_busy_w[2]} !== 3'b111) begin
      failures++;
      $display("FAIL mid_busy got %b%b%b want 111", init_busy_w[0], init_busy_w[1], init_busy_w[2]);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0; n = 0;
    for (int k = 0; k < 3; k++) done_at[k] = -1;
    while ((done_at[0] < 0 || done_at[1] < 0 || done_at[2] < 0) && n < 2000) begin
      cycle(); n++;
      for (int k = 0; k < 3; k++) begin
        if (init_busy_w[k] === 1'b0 && done_at[k] < 0) done_at[k] = n;
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (done_at[k] != MS[k]) begin
        failures++;
        $display("FAIL mid_clear_len dut%0d got %0d want %0d", k, done_at[k], MS[k]);
      end
    end
    ce0 = 1'b1; addr0 = 10'd5; ce1 = 1'b1; addr1 = 10'd3;
    cycle();
    idle_in();
    checks++;
    if (q0_w[0] !== 32'h0 || qv0_w[0] !== 1'b1 || q1_w[0] !== 32'h0 || q1_w[2] !== 32'h0) begin
      failures++;
      $display("FAIL mid_zero got %h/%b %h %h want 0/1 0 0", q0_w[0], qv0_w[0], q1_w[0], q1_w[2]);
    end
    cycle();
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_rd_mode();
    test_collision_ww();
    test_rw_conflict();
    test_back_to_back();
    test_random();
    test_midclear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
